mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_stage_data_ram.sv | 28 ++
 rtl/mem_stage.sv | 81 ++++++++
 tb/tb_mem_stage.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- widths and helpers shared by the memory pipeline stage.
//   DATA_W    : data path width
//   ADDR_W    : data-memory address width
//   MEM_DEPTH : number of data-memory words
//   branchTaken() : PC-select decision from jump/branch controls
package mem_stage_pkg;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 8;
   localparam int MEM_DEPTH = 256;

   // An unconditional jump wins over any conditional-branch outcome.
   function automatic logic branchTaken(input logic j, input logic jc,
                                        input logic neq, input logic zero);
      return j | (jc & (neq ? ~zero : zero));
   endfunction

endpackage

// File: rtl/mem_stage_data_ram.sv
// data_ram -- MEM_DEPTH x DATA_W data memory.
//   clock  : rising-edge clock
//   we     : write enable (synchronous write)
//   addr   : shared read/write address
//   wrData : write data
//   rdData : asynchronous read data, mem[addr]
// Contents have no reset.
module data_ram
   import mem_stage_pkg::*;
(
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wrData,
   output logic [DATA_W-1:0] rdData
);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wrData;
      end
   end

   assign rdData = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- memory pipeline stage: data memory access, writeback data
// select, branch resolution and control pipelining.
//   clock, reset_n        : rising-edge clock, async active-low reset
//   Wr, Wm, Rm            : regfile write, memory write, memory read enables
//   Neq, J, JC, zeroOut   : branch sense, jump, conditional jump, ALU zero
//   PC                    : current PC (link value)
//   acOutValue            : ALU result / memory address
//   RegVal                : store data
//   data_out              : registered writeback data
//   saidaA                : registered branch-taken / PC-select
//   Wr_MEM, Rm_MEM        : Wr and Rm delayed one cycle
// Build option: define MEM_LINK_EN to write PC back on J with Wr and no read
// (jump-and-link); otherwise PC is ignored.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              Wr,
   input  logic              Wm,
   input  logic              Rm,
   input  logic              Neq,
   input  logic              J,
   input  logic              JC,
   input  logic [DATA_W-1:0] PC,
   input  logic              zeroOut,
   input  logic [ADDR_W-1:0] acOutValue,
   input  logic [DATA_W-1:0] RegVal,
   output logic [DATA_W-1:0] data_out,
   output logic              saidaA,
   output logic              Wr_MEM,
   output logic              Rm_MEM
);

   logic [DATA_W-1:0] ramRdData;
   logic [DATA_W-1:0] nextData;
   logic              ramWe;
   logic              linkSel;

   // Memory must not be written while the stage is held in reset.
   assign ramWe = Wm & reset_n;

   data_ram uDataRam (
      .clock  (clock),
      .we     (ramWe),
      .addr   (acOutValue),
      .wrData (RegVal),
      .rdData (ramRdData)
   );

`ifdef MEM_LINK_EN
   assign linkSel = J & Wr;
`else
   assign linkSel = 1'b0;
`endif

   // A read that coincides with a write returns the store data (write-first).
   always_comb begin
      nextData = acOutValue;
      if (Rm) begin
         nextData = Wm ? RegVal : ramRdData;
      end else if (linkSel) begin
         nextData = PC;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= '0;
         saidaA   <= 1'b0;
         Wr_MEM   <= 1'b0;
         Rm_MEM   <= 1'b0;
      end else begin
         data_out <= nextData;
         saidaA   <= branchTaken(J, JC, Neq, zeroOut);
         Wr_MEM   <= Wr;
         Rm_MEM   <= Rm;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic       Wr = 0, Wm = 0, Rm = 0, Neq = 0, J = 0, JC = 0, zeroOut = 0;
   logic [7:0] PC = 0, acOutValue = 0, RegVal = 0;
   logic [7:0] data_out;
   logic       saidaA, Wr_MEM, Rm_MEM;

   int compared = 0;
   int mismatched = 0;

   mem_stage dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .Wr         (Wr),
      .Wm         (Wm),
      .Rm         (Rm),
      .Neq        (Neq),
      .J          (J),
      .JC         (JC),
      .PC         (PC),
      .zeroOut    (zeroOut),
      .acOutValue (acOutValue),
      .RegVal     (RegVal),
      .data_out   (data_out),
      .saidaA     (saidaA),
      .Wr_MEM     (Wr_MEM),
      .Rm_MEM     (Rm_MEM)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       wr, wm, rm, neq, j, jc, zero;
      logic [7:0] pc, ac, regVal;
      logic [7:0] expData;
      logic       expSaida, expWr, expRm;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      //            wr wm rm neq j jc z  pc     ac     regVal  expData saida wr rm
      vecs[0]  = '{0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h10, 8'h00, 0, 0, 0}; // store 0x10 @00
      vecs[1]  = '{0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h10, 0, 0, 1}; // load @00
      vecs[2]  = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h5A, 8'h00, 8'h5A, 0, 1, 0}; // ALU pass-through
      vecs[3]  = '{0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h01, 8'h00, 8'h01, 1, 0, 0}; // beq, zero
      vecs[4]  = '{0, 0, 0, 1, 0, 1, 1, 8'h00, 8'h02, 8'h00, 8'h02, 0, 0, 0}; // bne, zero
      vecs[5]  = '{0, 0, 0, 1, 0, 1, 0, 8'h00, 8'h03, 8'h00, 8'h03, 1, 0, 0}; // bne, nonzero
      vecs[6]  = '{0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h04, 8'h00, 8'h04, 0, 0, 0}; // beq, nonzero
      vecs[7]  = '{0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h20, 8'h33, 8'h33, 0, 0, 1}; // write-first
      vecs[8]  = '{0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h20, 8'h00, 8'h33, 0, 0, 1}; // mem[20] kept
      vecs[9]  = '{0, 0, 0, 0, 1, 1, 0, 8'h00, 8'h06, 8'h00, 8'h06, 1, 0, 0}; // J dominates
      vecs[10] = '{0, 0, 0, 0, 1, 0, 0, 8'h42, 8'h77, 8'h00, 8'h77, 1, 0, 0}; // J, no Wr: no link
      vecs[11] = '{1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h05, 8'hAB, 8'h05, 0, 1, 0}; // store 0xAB @05
      vecs[12] = '{1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h05, 8'h00, 8'hAB, 0, 1, 1}; // load @05

      // Reset state (asynchronous, before any clock edge).
      #1 reset_n = 1'b0;
      #1;
      check("rst data_out", data_out, 8'h00);
      check("rst saidaA",   {7'd0, saidaA}, 8'h00);
      check("rst Wr_MEM",   {7'd0, Wr_MEM}, 8'h00);
      check("rst Rm_MEM",   {7'd0, Rm_MEM}, 8'h00);
      tick();
      reset_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         Wr = vecs[i].wr; Wm = vecs[i].wm; Rm = vecs[i].rm; Neq = vecs[i].neq;
         J = vecs[i].j; JC = vecs[i].jc; zeroOut = vecs[i].zero;
         PC = vecs[i].pc; acOutValue = vecs[i].ac; RegVal = vecs[i].regVal;
         tick();
         check($sformatf("vec%0d data_out", i), data_out, vecs[i].expData);
         check($sformatf("vec%0d saidaA", i), {7'd0, saidaA}, {7'd0, vecs[i].expSaida});
         check($sformatf("vec%0d Wr_MEM", i), {7'd0, Wr_MEM}, {7'd0, vecs[i].expWr});
         check($sformatf("vec%0d Rm_MEM", i), {7'd0, Rm_MEM}, {7'd0, vecs[i].expRm});
      end

      // Mid-cycle reset: outputs clear immediately, memory untouched,
      // no write while held in reset.
      Wr = 1; Wm = 0; Rm = 1; J = 1; JC = 0; acOutValue = 8'h00;
      tick();
      check("pre-rst data_out", data_out, 8'h10);
      #3 reset_n = 1'b0;
      #1;
      check("mid-rst data_out", data_out, 8'h00);
      check("mid-rst saidaA",   {7'd0, saidaA}, 8'h00);
      check("mid-rst Wr_MEM",   {7'd0, Wr_MEM}, 8'h00);
      check("mid-rst Rm_MEM",   {7'd0, Rm_MEM}, 8'h00);
      Wm = 1; Rm = 0; RegVal = 8'hFF; acOutValue = 8'h00;
      tick();
      check("held-rst data_out", data_out, 8'h00);
      check("held-rst saidaA",   {7'd0, saidaA}, 8'h00);
      Wm = 0; Wr = 0; J = 0; Rm = 1; acOutValue = 8'h00;
      #3 reset_n = 1'b1;
      tick();
      check("post-rst load @00", data_out, 8'h10);
      check("post-rst Rm_MEM",   {7'd0, Rm_MEM}, 8'h01);
      check("post-rst saidaA",   {7'd0, saidaA}, 8'h00);

      // Jump with Wr and no read: link when enabled, pass-through otherwise.
      Rm = 0; Wm = 0; Wr = 1; J = 1; JC = 0; PC = 8'h42; acOutValue = 8'h11;
      tick();
`ifdef MEM_LINK_EN
      check("link data_out", data_out, 8'h42);
`else
      check("nolink data_out", data_out, 8'h11);
`endif
      check("link saidaA", {7'd0, saidaA}, 8'h01);
      check("link Wr_MEM", {7'd0, Wr_MEM}, 8'h01);

      // Read takes priority over link.
      Rm = 1; acOutValue = 8'h20;
      tick();
      check("link+read data_out", data_out, 8'h33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
